// File: rtl/unidad_control_micro.sv
// Multi-cycle control unit for a small accumulator-style micro: fetches 16-bit
// instructions, decodes them and sequences register-file writes, jumps and external input.
module unidad_control_micro #(
  parameter logic [7:0] DIR_RESET = 8'h00
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_instruccion,
  input  logic        i_dato_valido,
  input  logic        i_cero,
  output logic [7:0]  o_direccion_instruccion,
  output logic [2:0]  o_Sel_DW,
  output logic [7:0]  o_Num,
  output logic [2:0]  o_dir_rd,
  output logic [2:0]  o_dir_ry,
  output logic        o_we,
  output logic        o_dato_ack,
  output logic        o_halt
);

  // state     | meaning
  // FETCH     | latch instruction, advance PC
  // DECODE    | resolve opcode, take jumps
  // ESPERA    | wait for external data valid
  // WRITEBACK | one-cycle register-file write
  // HALT      | frozen until reset
  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_ESPERA    = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } estado_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDR0 = 4'd1;
  localparam logic [3:0] OP_IN   = 4'd2;
  localparam logic [3:0] OP_LDI  = 4'd3;
  localparam logic [3:0] OP_CALL = 4'd4;
  localparam logic [3:0] OP_MOV  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_JZ   = 4'd7;
  localparam logic [3:0] OP_HALT = 4'd8;

  estado_t     estado;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [3:0]  opcode;

  assign opcode = ir[15:12];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      estado <= S_FETCH;
      pc     <= DIR_RESET;
      ir     <= 16'h0000;
    end else begin
      case (estado)
        S_FETCH: begin
          ir     <= i_instruccion;
          pc     <= pc + 8'd1;
          estado <= S_DECODE;
        end
        S_DECODE: begin
          case (opcode)
            OP_LDR0, OP_LDI, OP_MOV, OP_CALL: estado <= S_WRITEBACK;
            OP_IN:   estado <= S_ESPERA;
            OP_HALT: estado <= S_HALT;
            OP_JMP: begin
              pc     <= ir[7:0];
              estado <= S_FETCH;
            end
            OP_JZ: begin
              if (i_cero) pc <= ir[7:0];
              estado <= S_FETCH;
            end
            default: estado <= S_FETCH;
          endcase
        end
        S_ESPERA: begin
          if (i_dato_valido) estado <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          // The link written this cycle is the incremented PC; redirect only afterwards.
          if (opcode == OP_CALL) pc <= ir[7:0];
          estado <= S_FETCH;
        end
        S_HALT: estado <= S_HALT;
        default: estado <= S_FETCH;
      endcase
    end
  end

  // Write-data source follows IR alone so it is stable from DECODE through WRITEBACK.
  always_comb begin
    o_Sel_DW = 3'd0;
    case (opcode)
      OP_LDR0: o_Sel_DW = 3'd0;
      OP_IN:   o_Sel_DW = 3'd1;
      OP_LDI:  o_Sel_DW = 3'd2;
      OP_CALL: o_Sel_DW = 3'd3;
      OP_MOV:  o_Sel_DW = 3'd4;
      default: o_Sel_DW = 3'd0;
    endcase
  end

  assign o_direccion_instruccion = pc;
  assign o_Num      = ir[7:0];
  assign o_dir_rd   = ir[11:9];
  assign o_dir_ry   = ir[8:6];
  assign o_we       = (estado == S_WRITEBACK);
  assign o_dato_ack = (estado == S_ESPERA) && i_dato_valido;
  assign o_halt     = (estado == S_HALT);

endmodule

// File: doc/unidad_control_micro.md
UNIDAD_CONTROL_MICRO -- requirements
Module: unidad_control_micro

Interface
REQ-001 Parameter: DIR_RESET, 8'h00, program counter value loaded on reset.
REQ-002 i_clk  input  1  single system clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_instruccion  input  16  instruction word at o_direccion_instruccion; combinational program memory, valid in the same cycle.
REQ-005 i_dato_valido  input  1  external input data valid; qualifies i_dato at the downstream selector.
REQ-006 i_cero  input  1  zero flag from datapath, sampled in DECODE.
REQ-007 o_direccion_instruccion  output  8  program counter; also selector source 3 (return link).
REQ-008 o_Sel_DW  output  3  write-data select to selector_micro: 0=R0, 1=i_dato, 2=Num, 3=o_direccion_instruccion, 4=Ry.
REQ-009 o_Num  output  8  immediate field IR[7:0].
REQ-010 o_dir_rd  output  3  destination register IR[11:9].
REQ-011 o_dir_ry  output  3  source register IR[8:6].
REQ-012 o_we  output  1  register-file write enable, one-cycle pulse.
REQ-013 o_dato_ack  output  1  one-cycle acknowledge of accepted external data.
REQ-014 o_halt  output  1  high while in HALT.

Function
REQ-015 Instruction format SHALL be: opcode IR[15:12], rd IR[11:9], ry IR[8:6], Num IR[7:0]; ry and Num overlap, each used only by the opcodes that need it.
REQ-016 Opcodes SHALL be: 0 NOP; 1 LDR0 (rd<-R0, Sel 0); 2 IN (rd<-i_dato, Sel 1); 3 LDI (rd<-Num, Sel 2); 4 CALL (rd<-PC, Sel 3, then PC<-Num); 5 MOV (rd<-Ry, Sel 4); 6 JMP (PC<-Num); 7 JZ (PC<-Num if i_cero); 8 HALT; 9-15 executed as NOP.
REQ-017 FSM states SHALL be FETCH, DECODE, ESPERA, WRITEBACK, HALT.
REQ-018 FETCH: IR<=i_instruccion, PC<=PC+1 modulo 256 (8'hFF wraps to 8'h00); next DECODE.
REQ-019 DECODE: NOP/illegal -> FETCH; JMP: PC<=Num -> FETCH; JZ: PC<=Num only if i_cero=1 -> FETCH; LDR0/LDI/MOV/CALL -> WRITEBACK; IN -> ESPERA; HALT -> HALT.
REQ-020 ESPERA: stay while i_dato_valido=0; when 1, assert o_dato_ack that cycle and go to WRITEBACK.
REQ-021 WRITEBACK: o_we=1 for exactly this cycle; for CALL, PC<=Num at the end of this cycle so the written link equals the already-incremented PC; next FETCH.
REQ-022 o_we and o_dato_ack SHALL be Moore/state-decoded, never asserted outside WRITEBACK/ESPERA respectively.
REQ-023 o_Sel_DW, o_Num, o_dir_rd, o_dir_ry SHALL derive from IR only and stay stable from DECODE through WRITEBACK; o_Sel_DW=0 for opcodes without register write.
REQ-024 Latency: NOP/JMP/JZ 2 cycles; LDR0/LDI/MOV/CALL 3 cycles; IN 3 cycles plus wait cycles.
REQ-025 HALT SHALL be absorbing: o_halt=1, PC frozen, o_we=0 until reset.
REQ-026 i_dato_valido outside ESPERA SHALL be ignored; no ack issued.

Reset
REQ-027 While i_rst_n=0 at a clock edge: PC<=DIR_RESET, IR<=16'h0000, state<=FETCH; reset SHALL override any state including ESPERA, WRITEBACK and HALT.
REQ-028 Reset output values: o_direccion_instruccion=DIR_RESET, o_we=0, o_dato_ack=0, o_halt=0, o_Sel_DW=0, o_Num=0, o_dir_rd=0, o_dir_ry=0.
REQ-029 Reset asserted during WRITEBACK SHALL suppress that o_we pulse (o_we=0 in the cycle after the reset edge).

Verification
REQ-030 LDI: instr 16'h3A05 at PC 0 -> DECODE shows o_Sel_DW=2, o_dir_rd=5, o_Num=8'h05; o_we high one cycle 3rd cycle; next fetch PC=1.
REQ-031 CALL: instr 16'h4640 at PC 8'h10 -> WRITEBACK with o_Sel_DW=3, o_dir_rd=3, o_direccion_instruccion=8'h11, o_we=1; next FETCH at PC=8'h40.
REQ-032 IN: instr 16'h2200, i_dato_valido held 0 for 4 cycles then 1 -> stays ESPERA 4 cycles, o_dato_ack one pulse, o_we next cycle with o_Sel_DW=1, o_dir_rd=1.
REQ-033 JZ: 16'h7020 with i_cero=0 -> PC continues sequentially; with i_cero=1 -> next fetch at 8'h20; o_we never asserted.
REQ-034 Wrap/HALT: NOP at PC 8'hFF -> next fetch PC 8'h00; HALT 16'h8000 -> o_halt=1, PC frozen for 10 cycles; i_rst_n=0 one edge -> PC=DIR_RESET, o_halt=0.
REQ-035 Mid-op reset: assert i_rst_n=0 in ESPERA and in WRITEBACK -> no o_dato_ack/o_we pulse after the edge; FSM in FETCH, all outputs at REQ-028 values.
